// File: rtl/coin_pkg.sv
// Shared encodings and constants for the coin sprite generator.
package coin_pkg;

  typedef enum logic [1:0] {
    SPAWN   = 2'd0,
    ACTIVE  = 2'd1,
    COLLECT = 2'd2,
    WAIT    = 2'd3
  } state_t;

  localparam logic [9:0]  SPAWN_X_OFS = 10'd64;
  localparam logic [9:0]  SPAWN_Y_OFS = 10'd112;
  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with XOR feedback into bit 0 while enabled.
module lfsr16
  import coin_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/coin_gen.sv
// Coin sprite: LFSR-placed square, per-frame overlap test, score and timed respawn.
// Optional COIN_BLINK_EN blinks the coin with an 8-frame on/off cadence.
module coin_gen
  import coin_pkg::*;
#(
  parameter int          COIN_SIZE      = 16,
  parameter int          CHAR_SIZE      = 32,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [2:0]  COIN_COLOR     = 3'b110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic [9:0] char_x,
  input  logic [9:0] char_y,
  output logic       r_coin,
  output logic       g_coin,
  output logic       b_coin,
  output logic       coin_collected,
  output logic [7:0] score
);

  localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);

  logic [15:0]      lfsr;
  state_t           state_q, state_d;
  logic [9:0]       coin_x_q, coin_x_d;
  logic [9:0]       coin_y_q, coin_y_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       score_q, score_d;
  logic             coin_collected_q, coin_collected_d;
  logic [2:0]       rgb_q, rgb_d;
`ifdef COIN_BLINK_EN
  logic [3:0]       blink_cnt_q, blink_cnt_d;
`endif

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .state (lfsr)
  );

  // 11-bit compares so box edges near 1023 never wrap
  logic [10:0] coin_xl, coin_xh, coin_yl, coin_yh;
  logic [10:0] char_xl, char_xh, char_yl, char_yh;
  logic [10:0] pix_x, pix_y;
  logic        hit, in_box, show;

  always_comb begin
    coin_xl = {1'b0, coin_x_q};
    coin_yl = {1'b0, coin_y_q};
    coin_xh = coin_xl + 11'(COIN_SIZE);
    coin_yh = coin_yl + 11'(COIN_SIZE);
    char_xl = {1'b0, char_x};
    char_yl = {1'b0, char_y};
    char_xh = char_xl + 11'(CHAR_SIZE);
    char_yh = char_yl + 11'(CHAR_SIZE);
    pix_x   = {1'b0, pixel_x};
    pix_y   = {1'b0, pixel_y};
    hit     = (coin_xl < char_xh) && (char_xl < coin_xh) &&
              (coin_yl < char_yh) && (char_yl < coin_yh);
    in_box  = (pix_x >= coin_xl) && (pix_x < coin_xh) &&
              (pix_y >= coin_yl) && (pix_y < coin_yh);
`ifdef COIN_BLINK_EN
    show    = ~blink_cnt_q[3];
`else
    show    = 1'b1;
`endif
  end

  always_comb begin
    state_d          = state_q;
    coin_x_d         = coin_x_q;
    coin_y_d         = coin_y_q;
    frame_cnt_d      = frame_cnt_q;
    score_d          = score_q;
    coin_collected_d = 1'b0;
`ifdef COIN_BLINK_EN
    blink_cnt_d      = blink_cnt_q;
`endif
    case (state_q)
      SPAWN: begin
        coin_x_d = SPAWN_X_OFS + {1'b0, lfsr[8:0]};
        coin_y_d = SPAWN_Y_OFS + {2'b00, lfsr[15:8]};
        state_d  = ACTIVE;
`ifdef COIN_BLINK_EN
        blink_cnt_d = 4'd0;
`endif
      end
      ACTIVE: begin
        if (frame_tick) begin
`ifdef COIN_BLINK_EN
          blink_cnt_d = blink_cnt_q + 4'd1;
`endif
          if (hit) state_d = COLLECT;
        end
      end
      COLLECT: begin
        coin_collected_d = 1'b1;
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        frame_cnt_d = CNT_W'(RESPAWN_FRAMES);
        state_d     = WAIT;
      end
      WAIT: begin
        if (frame_tick) begin
          frame_cnt_d = frame_cnt_q - CNT_W'(1);
          if (frame_cnt_q <= CNT_W'(1)) state_d = SPAWN;
        end
      end
      default: state_d = SPAWN;
    endcase
    rgb_d = (state_q == ACTIVE && video_on && in_box && show) ? COIN_COLOR : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= SPAWN;
      coin_x_q         <= '0;
      coin_y_q         <= '0;
      frame_cnt_q      <= '0;
      score_q          <= '0;
      coin_collected_q <= 1'b0;
      rgb_q            <= '0;
`ifdef COIN_BLINK_EN
      blink_cnt_q      <= '0;
`endif
    end else begin
      state_q          <= state_d;
      coin_x_q         <= coin_x_d;
      coin_y_q         <= coin_y_d;
      frame_cnt_q      <= frame_cnt_d;
      score_q          <= score_d;
      coin_collected_q <= coin_collected_d;
      rgb_q            <= rgb_d;
`ifdef COIN_BLINK_EN
      blink_cnt_q      <= blink_cnt_d;
`endif
    end
  end

  assign {r_coin, g_coin, b_coin} = rgb_q;
  assign coin_collected           = coin_collected_q;
  assign score                    = score_q;

endmodule

// File: tb/tb_coin_gen.sv
// Directed bench for coin_gen: main instance plus a RESPAWN_FRAMES=1 instance for score saturation.
module tb_coin_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on;
  logic       frame_tick, sat_tick;
  logic [9:0] char_x, char_y, sat_cx, sat_cy;
  logic       r_coin, g_coin, b_coin, coin_collected;
  logic [7:0] score;
  logic       sr, sg, sb, s_collected;
  logic [7:0] s_score;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coin_gen dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .char_x(char_x), .char_y(char_y),
    .r_coin(r_coin), .g_coin(g_coin), .b_coin(b_coin),
    .coin_collected(coin_collected), .score(score)
  );

  coin_gen #(.RESPAWN_FRAMES(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(sat_tick), .char_x(sat_cx), .char_y(sat_cy),
    .r_coin(sr), .g_coin(sg), .b_coin(sb),
    .coin_collected(s_collected), .score(s_score)
  );

  // Reference LFSR written out from the tap list 16,14,13,11
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {29'd0, r_coin, g_coin, b_coin};
  endfunction

  logic [9:0] ex, ey;
  logic [7:0] exp_score;

  initial begin
    rst_n = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    frame_tick = 1'b0; sat_tick = 1'b0;
    char_x = '0; char_y = '0; sat_cx = '0; sat_cy = '0;
    repeat (3) step();
    chk("reset_rgb", rgb(), 32'd0);
    chk("reset_score", {24'd0, score}, 32'd0);
    chk("reset_pulse", {31'd0, coin_collected}, 32'd0);

    // First edge after release is SPAWN; coin lands at (289,284)
    rst_n = 1'b1;
    pixel_x = 10'd289; pixel_y = 10'd284; video_on = 1'b1;
    step();
    chk("spawn_cycle_blank", rgb(), 32'd0);
    step();
    chk("draw_top_left", rgb(), 32'd6);
    pixel_x = 10'd304; pixel_y = 10'd299;
    step();
    chk("draw_bot_right", rgb(), 32'd6);
    pixel_x = 10'd305; pixel_y = 10'd284;
    step();
    chk("draw_right_edge_out", rgb(), 32'd0);
    pixel_x = 10'd289; pixel_y = 10'd283;
    step();
    chk("draw_top_edge_out", rgb(), 32'd0);
    pixel_x = 10'd289; pixel_y = 10'd284; video_on = 1'b0;
    step();
    chk("draw_video_off", rgb(), 32'd0);
    video_on = 1'b1;

    // Touching edges on each side must not collect
    char_x = 10'd257; char_y = 10'd284; tick(); step();
    chk("edge_left_pulse", {31'd0, coin_collected}, 32'd0);
    char_x = 10'd305; char_y = 10'd284; tick(); step();
    chk("edge_right_pulse", {31'd0, coin_collected}, 32'd0);
    char_x = 10'd289; char_y = 10'd252; tick(); step();
    chk("edge_top_pulse", {31'd0, coin_collected}, 32'd0);
    chk("edge_score", {24'd0, score}, 32'd0);
    chk("edge_still_drawn", rgb(), 32'd6);

    // Overlapping character collects
    char_x = 10'd280; char_y = 10'd270;
    tick();
    chk("collect_pre_pulse", {31'd0, coin_collected}, 32'd0);
    step();
    chk("collect_pulse", {31'd0, coin_collected}, 32'd1);
    chk("collect_score", {24'd0, score}, 32'd1);
    step();
    chk("collect_pulse_end", {31'd0, coin_collected}, 32'd0);
    chk("collect_score_hold", {24'd0, score}, 32'd1);
    chk("collect_not_drawn", rgb(), 32'd0);

    // Respawn after exactly 60 ticks
    repeat (59) tick();
    step();
    chk("wait59_not_drawn", rgb(), 32'd0);
    chk("wait59_score", {24'd0, score}, 32'd1);
    tick();
    ex = 10'd64 + {1'b0, m_lfsr[8:0]};
    ey = 10'd112 + {2'b00, m_lfsr[15:8]};
    char_x = 10'd0; char_y = 10'd0;
    pixel_x = ex; pixel_y = ey;
    step();
    chk("respawn_spawn_blank", rgb(), 32'd0);
    step();
    chk("respawn_drawn", rgb(), 32'd6);
    pixel_x = ex + 10'd16;
    step();
    chk("respawn_right_out", rgb(), 32'd0);
    pixel_x = ex + 10'd15; pixel_y = ey + 10'd15;
    step();
    chk("respawn_corner_in", rgb(), 32'd6);
    pixel_x = ex; pixel_y = ey;

    // Blink cadence, or steady drawing when blink is not built in
    for (int k = 0; k < 16; k++) begin
      step();
`ifdef COIN_BLINK_EN
      chk("blink_frame", rgb(), (k < 8) ? 32'd6 : 32'd0);
`else
      chk("steady_frame", rgb(), 32'd6);
`endif
      tick();
    end
    chk("blink_no_collect_score", {24'd0, score}, 32'd1);

    // Saturation on the fast-respawn instance, which has sat at (289,284) since reset
    ex = 10'd289; ey = 10'd284;
    for (int i = 0; i < 256; i++) begin
      sat_cx = ex; sat_cy = ey;
      sat_tick = 1'b1; step(); sat_tick = 1'b0;
      step();
      exp_score = (i >= 254) ? 8'd255 : 8'(i + 1);
      chk("sat_pulse", {31'd0, s_collected}, 32'd1);
      chk("sat_score", {24'd0, s_score}, {24'd0, exp_score});
      sat_tick = 1'b1; step(); sat_tick = 1'b0;
      ex = 10'd64 + {1'b0, m_lfsr[8:0]};
      ey = 10'd112 + {2'b00, m_lfsr[15:8]};
      step();
    end
    chk("sat_final_score", {24'd0, s_score}, 32'd255);

    // Asynchronous reset clears immediately, away from any edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_score", {24'd0, score}, 32'd0);
    chk("async_rst_sat_score", {24'd0, s_score}, 32'd0);
    chk("async_rst_rgb", rgb(), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
